// File: rtl/branch_predictor.sv
// branch_predictor
// ----------------
// Direct-mapped branch target buffer. Each entry holds a saturating direction
// counter. Lookup is purely combinational, so the fetch stage gets a
// prediction in the same cycle. The execute stage trains the table one cycle
// later through the registered update port.
//
// Parameters
//   ENTRIES : number of table entries (power of two, >= 2)
//   CTR_W   : direction counter width (>= 1)
//   STAT_W  : width of each statistics counter
//
// Ports
//   CLK, nRST              : clock and synchronous active-low reset
//   en                     : pipeline enable; gates updates and statistics
//   lookup_pc              : fetch-stage PC
//   pred_taken/target/hit  : combinational prediction for lookup_pc
//   upd_valid/pc/taken/target/mispred : resolved branch from execute
//   clear_all              : invalidate every entry (works even when en=0)
//   hit_cnt, mispred_cnt   : saturating statistics counters
module branch_predictor #(
  parameter int ENTRIES = 16,
  parameter int CTR_W   = 2,
  parameter int STAT_W  = 16
) (
  input  logic              CLK,
  input  logic              nRST,
  input  logic              en,
  input  logic [31:0]       lookup_pc,
  output logic              pred_taken,
  output logic [31:0]       pred_target,
  output logic              pred_hit,
  input  logic              upd_valid,
  input  logic [31:0]       upd_pc,
  input  logic              upd_taken,
  input  logic [31:0]       upd_target,
  input  logic              upd_mispred,
  input  logic              clear_all,
  output logic [STAT_W-1:0] hit_cnt,
  output logic [STAT_W-1:0] mispred_cnt
);

  localparam int IDX_W = $clog2(ENTRIES);
  localparam int TAG_W = 30 - IDX_W;

  localparam logic [CTR_W-1:0] CTR_MAX = '1;
  localparam logic [CTR_W-1:0] CTR_WT  = CTR_W'(1) << (CTR_W - 1);
  localparam logic [CTR_W-1:0] CTR_WNT = CTR_WT - CTR_W'(1);

  logic [ENTRIES-1:0] valid;
  logic [TAG_W-1:0]   tags    [ENTRIES];
  logic [31:0]        targets [ENTRIES];
  logic [CTR_W-1:0]   ctrs    [ENTRIES];

  logic [IDX_W-1:0] lookupIdx;
  logic [TAG_W-1:0] lookupTag;
  logic [IDX_W-1:0] updIdx;
  logic [TAG_W-1:0] updTag;
  logic             updHit;
  logic             doUpdate;

  assign lookupIdx = lookup_pc[IDX_W+1:2];
  assign lookupTag = lookup_pc[31:IDX_W+2];
  assign updIdx    = upd_pc[IDX_W+1:2];
  assign updTag    = upd_pc[31:IDX_W+2];

  // Prediction path. Stale tags/targets behind a cleared valid bit never
  // reach the outputs because everything is qualified by pred_hit.
  always_comb begin
    pred_hit    = valid[lookupIdx] && (tags[lookupIdx] == lookupTag);
    pred_taken  = pred_hit && ctrs[lookupIdx][CTR_W-1];
    pred_target = pred_taken ? targets[lookupIdx] : (lookup_pc + 32'd4);
  end

  assign updHit   = valid[updIdx] && (tags[updIdx] == updTag);
  assign doUpdate = en && upd_valid;

  // Valid bits and direction counters. Reset beats clear_all, which in turn
  // beats a training update in the same cycle.
  always_ff @(posedge CLK) begin
    if (!nRST) begin
      valid <= '0;
      for (int i = 0; i < ENTRIES; i++) begin
        ctrs[i] <= CTR_WNT;
      end
    end else if (clear_all) begin
      valid <= '0;
    end else if (doUpdate) begin
      if (updHit) begin
        if (upd_taken) begin
          if (ctrs[updIdx] != CTR_MAX) begin
            ctrs[updIdx] <= ctrs[updIdx] + CTR_W'(1);
          end
        end else begin
          if (ctrs[updIdx] != '0) begin
            ctrs[updIdx] <= ctrs[updIdx] - CTR_W'(1);
          end
        end
      end else if (upd_taken) begin
        valid[updIdx] <= 1'b1;
        ctrs[updIdx]  <= CTR_WT;
      end
    end
  end

  // Tags and targets carry no reset; they are meaningless until valid is set.
  // The target follows every taken resolution, on hit or on allocation.
  always_ff @(posedge CLK) begin
    if (nRST && !clear_all && doUpdate && upd_taken) begin
      targets[updIdx] <= upd_target;
      if (!updHit) begin
        tags[updIdx] <= updTag;
      end
    end
  end

  // Statistics. Independent of clear_all; both stop at all-ones.
  always_ff @(posedge CLK) begin
    if (!nRST) begin
      hit_cnt     <= '0;
      mispred_cnt <= '0;
    end else if (en) begin
      if (pred_hit && (hit_cnt != '1)) begin
        hit_cnt <= hit_cnt + STAT_W'(1);
      end
      if (upd_valid && upd_mispred && (mispred_cnt != '1)) begin
        mispred_cnt <= mispred_cnt + STAT_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_branch_predictor.sv
// tb_branch_predictor
// -------------------
// Directed bench for branch_predictor. Two instances share all inputs: one
// with default statistics width, one with 4-bit statistics to reach the
// saturation point quickly. A high-level model (per-entry records with an
// integer counter) predicts every output each cycle; literal expectations
// pin the key scenarios.
module tb_branch_predictor;

  logic        CLK = 1'b0;
  logic        nRST;
  logic        en;
  logic [31:0] lookup_pc;
  logic        upd_valid;
  logic [31:0] upd_pc;
  logic        upd_taken;
  logic [31:0] upd_target;
  logic        upd_mispred;
  logic        clear_all;

  logic        predTakenA, predHitA, predTakenB, predHitB;
  logic [31:0] predTargetA, predTargetB;
  logic [15:0] hitCntA, misCntA;
  logic [3:0]  hitCntB, misCntB;

  int errors = 0;
  int checks = 0;
  bit armed  = 1'b0;

  // Model state: one record per table slot, counter kept as a plain integer.
  bit          mValid  [16];
  logic [25:0] mTag    [16];
  logic [31:0] mTarget [16];
  int          mCtr    [16];
  int          mHit16, mMis16, mHit4, mMis4;

  always #5 CLK = ~CLK;

  branch_predictor #(.ENTRIES(16), .CTR_W(2), .STAT_W(16)) dutA (
    .CLK(CLK), .nRST(nRST), .en(en), .lookup_pc(lookup_pc),
    .pred_taken(predTakenA), .pred_target(predTargetA), .pred_hit(predHitA),
    .upd_valid(upd_valid), .upd_pc(upd_pc), .upd_taken(upd_taken),
    .upd_target(upd_target), .upd_mispred(upd_mispred), .clear_all(clear_all),
    .hit_cnt(hitCntA), .mispred_cnt(misCntA)
  );

  branch_predictor #(.ENTRIES(16), .CTR_W(2), .STAT_W(4)) dutB (
    .CLK(CLK), .nRST(nRST), .en(en), .lookup_pc(lookup_pc),
    .pred_taken(predTakenB), .pred_target(predTargetB), .pred_hit(predHitB),
    .upd_valid(upd_valid), .upd_pc(upd_pc), .upd_taken(upd_taken),
    .upd_target(upd_target), .upd_mispred(upd_mispred), .clear_all(clear_all),
    .hit_cnt(hitCntB), .mispred_cnt(misCntB)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s actual=0x%08h required=0x%08h", name, act, exp);
    end
  endtask

  // Prediction from the model: slot = word address mod 16, tag = the rest.
  task automatic modelLookup(input logic [31:0] pc, output bit hit, output bit taken,
                             output logic [31:0] target);
    int slot;
    slot   = int'((pc >> 2) % 16);
    hit    = mValid[slot] && (mTag[slot] == 26'(pc >> 6));
    taken  = hit && (mCtr[slot] >= 2);
    target = taken ? mTarget[slot] : pc + 32'd4;
  endtask

  // Advance the model across one rising edge using the inputs now applied.
  task automatic modelEdge();
    bit hit, taken, uHit, uTaken;
    logic [31:0] tgt, uTgt;
    int slot;
    modelLookup(lookup_pc, hit, taken, tgt);
    modelLookup(upd_pc, uHit, uTaken, uTgt);
    slot = int'((upd_pc >> 2) % 16);
    if (!nRST) begin
      for (int i = 0; i < 16; i++) begin
        mValid[i] = 1'b0;
        mCtr[i]   = 1;
      end
      mHit16 = 0; mMis16 = 0; mHit4 = 0; mMis4 = 0;
      return;
    end
    if (en && hit) begin
      if (mHit16 < 65535) mHit16++;
      if (mHit4 < 15) mHit4++;
    end
    if (en && upd_valid && upd_mispred) begin
      if (mMis16 < 65535) mMis16++;
      if (mMis4 < 15) mMis4++;
    end
    if (clear_all) begin
      for (int i = 0; i < 16; i++) mValid[i] = 1'b0;
    end else if (en && upd_valid) begin
      if (uHit) begin
        if (upd_taken) begin
          if (mCtr[slot] < 3) mCtr[slot]++;
          mTarget[slot] = upd_target;
        end else if (mCtr[slot] > 0) begin
          mCtr[slot]--;
        end
      end else if (upd_taken) begin
        mValid[slot]  = 1'b1;
        mTag[slot]    = 26'(upd_pc >> 6);
        mTarget[slot] = upd_target;
        mCtr[slot]    = 2;
      end
    end
  endtask

  // Per-cycle comparison of both instances against the model.
  task automatic checkOutput();
    bit hit, taken;
    logic [31:0] tgt;
    if (!armed) return;
    modelLookup(lookup_pc, hit, taken, tgt);
    check("hitA",     {31'd0, predHitA},   {31'd0, hit});
    check("takenA",   {31'd0, predTakenA}, {31'd0, taken});
    check("targetA",  predTargetA,         tgt);
    check("hitB",     {31'd0, predHitB},   {31'd0, hit});
    check("takenB",   {31'd0, predTakenB}, {31'd0, taken});
    check("targetB",  predTargetB,         tgt);
    check("hitCntA",  {16'd0, hitCntA},    mHit16);
    check("misCntA",  {16'd0, misCntA},    mMis16);
    check("hitCntB",  {28'd0, hitCntB},    mHit4);
    check("misCntB",  {28'd0, misCntB},    mMis4);
  endtask

  task automatic applyStimulus(input logic e, input logic uv, input logic [31:0] upc,
                               input logic ut, input logic [31:0] utgt, input logic um,
                               input logic clr, input logic [31:0] lpc);
    en = e; upd_valid = uv; upd_pc = upc; upd_taken = ut; upd_target = utgt;
    upd_mispred = um; clear_all = clr; lookup_pc = lpc;
    #1;
    checkOutput();
  endtask

  task automatic step();
    @(posedge CLK);
    modelEdge();
    #1;
  endtask

  task automatic lookupOnly(input logic [31:0] lpc);
    applyStimulus(1'b1, 1'b0, 32'd0, 1'b0, 32'd0, 1'b0, 1'b0, lpc);
  endtask

  task automatic train(input logic [31:0] pc, input logic t, input logic [31:0] tgt,
                       input logic m);
    applyStimulus(1'b1, 1'b1, pc, t, tgt, m, 1'b0, pc);
    step();
  endtask

  initial begin
    nRST = 1'b0;
    applyStimulus(1'b1, 1'b0, 32'd0, 1'b0, 32'd0, 1'b0, 1'b0, 32'h40);
    step();
    step();
    armed = 1'b1;
    nRST  = 1'b1;

    // Reset state
    lookupOnly(32'h40);
    check("rst_hit",    {31'd0, predHitA},   32'd0);
    check("rst_taken",  {31'd0, predTakenA}, 32'd0);
    check("rst_target", predTargetA,         32'h44);
    check("rst_hitcnt", {16'd0, hitCntA},    32'd0);
    check("rst_miscnt", {16'd0, misCntA},    32'd0);
    step();

    // Allocation on a mispredicted taken branch
    train(32'h100, 1'b1, 32'h200, 1'b1);
    lookupOnly(32'h100);
    check("alloc_hit",    {31'd0, predHitA},   32'd1);
    check("alloc_taken",  {31'd0, predTakenA}, 32'd1);
    check("alloc_target", predTargetA,         32'h200);
    check("alloc_miscnt", {16'd0, misCntA},    32'd1);
    step();

    // Saturate up, then walk down to not-taken
    for (int i = 0; i < 3; i++) train(32'h100, 1'b1, 32'h200, 1'b0);
    for (int i = 0; i < 2; i++) train(32'h100, 1'b0, 32'h0, 1'b0);
    lookupOnly(32'h100);
    check("down_hit",    {31'd0, predHitA},   32'd1);
    check("down_taken",  {31'd0, predTakenA}, 32'd0);
    check("down_target", predTargetA,         32'h104);
    step();
    for (int i = 0; i < 2; i++) train(32'h100, 1'b0, 32'h0, 1'b1);
    lookupOnly(32'h100);
    check("floor_taken", {31'd0, predTakenA}, 32'd0);
    step();
    train(32'h100, 1'b1, 32'h200, 1'b0);
    lookupOnly(32'h100);
    check("floor_plus1_taken", {31'd0, predTakenA}, 32'd0);
    step();

    // Aliasing slot 0 with a different tag
    lookupOnly(32'h140);
    check("alias_miss",   {31'd0, predHitA}, 32'd0);
    check("alias_target", predTargetA,       32'h144);
    step();
    applyStimulus(1'b1, 1'b1, 32'h140, 1'b1, 32'h300, 1'b1, 1'b0, 32'h140);
    check("same_cycle_miss", {31'd0, predHitA}, 32'd0);
    step();
    lookupOnly(32'h100);
    check("evicted_miss",   {31'd0, predHitA}, 32'd0);
    check("evicted_target", predTargetA,       32'h104);
    step();
    lookupOnly(32'h140);
    check("replaced_taken",  {31'd0, predTakenA}, 32'd1);
    check("replaced_target", predTargetA,         32'h300);
    step();

    // clear_all overrides a simultaneous update
    applyStimulus(1'b1, 1'b1, 32'h180, 1'b1, 32'h400, 1'b0, 1'b1, 32'h44);
    step();
    lookupOnly(32'h140);
    check("clear_miss140", {31'd0, predHitA}, 32'd0);
    step();
    lookupOnly(32'h180);
    check("clear_miss180", {31'd0, predHitA}, 32'd0);
    check("clear_target",  predTargetA,       32'h184);
    step();

    // en=0 freezes the table and statistics
    train(32'h100, 1'b1, 32'h500, 1'b0);
    applyStimulus(1'b0, 1'b1, 32'h100, 1'b0, 32'h0, 1'b1, 1'b0, 32'h100);
    step();
    applyStimulus(1'b0, 1'b1, 32'h100, 1'b0, 32'h0, 1'b1, 1'b0, 32'h100);
    step();
    lookupOnly(32'h100);
    check("frozen_taken",  {31'd0, predTakenA}, 32'd1);
    check("frozen_target", predTargetA,         32'h500);
    step();

    // Drive the 4-bit hit counter into saturation
    for (int i = 0; i < 20; i++) begin
      lookupOnly(32'h100);
      step();
    end
    lookupOnly(32'h100);
    check("hitcnt4_sat", {28'd0, hitCntB}, 32'd15);
    step();

    // PC wrap on the fall-through target
    lookupOnly(32'hFFFF_FFFC);
    check("wrap_target", predTargetA, 32'h0);
    step();

    // Reset mid-operation drops the same-edge update
    nRST = 1'b0;
    applyStimulus(1'b1, 1'b1, 32'h200, 1'b1, 32'h600, 1'b1, 1'b0, 32'h100);
    step();
    nRST = 1'b1;
    lookupOnly(32'h200);
    check("rst2_miss200",  {31'd0, predHitA}, 32'd0);
    check("rst2_target",   predTargetA,       32'h204);
    check("rst2_miscnt",   {16'd0, misCntA},  32'd0);
    step();
    lookupOnly(32'h100);
    check("rst2_miss100",  {31'd0, predHitA}, 32'd0);
    step();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/branch_predictor.md
BRANCH_PREDICTOR -- requirements
Module: branch_predictor

Interface
REQ-001 Parameter ENTRIES, default 16, meaning number of direct-mapped table entries; power of two and at least 2.
REQ-002 Parameter CTR_W, default 2, meaning saturating direction-counter width; at least 1.
REQ-003 Parameter STAT_W, default 16, meaning width of each statistics counter.
REQ-004 Derived widths: IDX_W = log2(ENTRIES); TAG_W = 30 - IDX_W.
REQ-005 CLK  in  1  clock; all state changes on the rising edge.
REQ-006 nRST  in  1  reset, synchronous, active-low.
REQ-007 en  in  1  pipeline enable (ihit and not halted); gates all updates and statistics.
REQ-008 lookup_pc  in  32  fetch-stage PC.
REQ-009 pred_taken  out  1  predicted-taken for lookup_pc.
REQ-010 pred_target  out  32  predicted next PC.
REQ-011 pred_hit  out  1  lookup_pc matched a valid entry.
REQ-012 upd_valid  in  1  execute-stage resolved branch present.
REQ-013 upd_pc  in  32  PC of the resolved branch.
REQ-014 upd_taken  in  1  resolved direction.
REQ-015 upd_target  in  32  resolved taken target.
REQ-016 upd_mispred  in  1  the resolved branch was mispredicted.
REQ-017 clear_all  in  1  invalidate the whole table.
REQ-018 hit_cnt  out  STAT_W  count of enabled lookups that hit.
REQ-019 mispred_cnt  out  STAT_W  count of enabled mispredicted updates.

Function
REQ-020 Index = pc[IDX_W+1:2]; tag = pc[31:IDX_W+2]; pc[1:0] ignored.
REQ-021 Each entry holds valid (1 bit), tag (TAG_W), target (32) and counter (CTR_W).
REQ-022 Lookup is combinational, zero latency: pred_hit = valid and tag match at index(lookup_pc).
REQ-023 pred_taken = pred_hit and counter MSB; pred_target = stored target if pred_taken, else lookup_pc + 4, with 32-bit wrap (0xFFFFFFFC gives 0x00000000).
REQ-024 An update occurs on an edge with en=1, upd_valid=1 and clear_all=0; with en=0 all table state and statistics hold.
REQ-025 Update hit (valid and tag match at index(upd_pc)): counter +1 saturating at 2^CTR_W-1 if taken, -1 saturating at 0 if not taken; target overwritten only if taken.
REQ-026 Update miss with taken: allocate; valid=1, tag and target written, counter = 2^(CTR_W-1) (weakly taken); any aliased entry is replaced.
REQ-027 Update miss with not taken: no table change.
REQ-028 Writes are registered: a lookup in the same cycle as an update to the same index returns pre-update state; new state is visible the next cycle.
REQ-029 clear_all=1 at an edge (independent of en) clears every valid bit; it overrides a simultaneous update; tags, targets and counters may keep stale values.
REQ-030 hit_cnt increments on edges with en=1 and pred_hit=1; mispred_cnt increments on edges with en=1, upd_valid=1 and upd_mispred=1; both saturate at all-ones; clear_all does not affect them.
REQ-031 All outputs are driven every cycle; there are no X outputs after reset.

Reset
REQ-032 nRST=0 at an edge clears all valid bits, sets every counter to 2^(CTR_W-1)-1 (weakly not taken), and zeroes hit_cnt and mispred_cnt; nRST has priority over clear_all and updates.
REQ-033 Reset asserted mid-operation discards any same-edge update; after release, every lookup misses and returns pc + 4.

Verification
REQ-034 Reset then lookup_pc=0x40 -> pred_hit=0, pred_taken=0, pred_target=0x44, hit_cnt=0, mispred_cnt=0.
REQ-035 Update pc=0x100, taken, target=0x200, mispred=1 -> next cycle lookup 0x100 gives pred_hit=1, pred_taken=1, pred_target=0x200, mispred_cnt=1.
REQ-036 Three more taken updates to 0x100 (counter saturates at 3), then two not-taken -> pred_taken=0, pred_target=0x104, pred_hit=1; two further not-taken -> counter holds at 0.
REQ-037 Alias with 0x140 (same index 0, different tag): lookup misses; taken update with target 0x300 replaces the entry -> 0x100 misses and 0x140 predicts 0x300.
REQ-038 clear_all=1 with a simultaneous taken update to 0x180 -> next cycle all lookups miss and statistics are unchanged.
REQ-039 en=0 with upd_valid=1 and a hitting lookup -> table, hit_cnt and mispred_cnt are unchanged.
REQ-040 Force hit_cnt to all-ones with STAT_W=4 (15 hitting lookups), then apply further hits -> hit_cnt stays at 15.
